// File: rtl/buffer_fifo_nx.sv
`default_nettype none
// ============================================================================
// Module   : buffer_fifo_nx
// Purpose  : WIDTH-bit, DEPTH-entry synchronous FIFO buffer with valid/ready
//            handshakes on both sides. First-word fall-through read path,
//            status flags derived only from registered pointers.
// Options  : define BUFFER_FIFO_NX_COUNT_EN to add the COUNT occupancy port.
// Revision : 1.0 - initial release
// ============================================================================
module buffer_fifo_nx #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] I,
   input  logic             I_VALID,
   output logic             I_READY,
   output logic [WIDTH-1:0] O,
   output logic             O_VALID,
   input  logic             O_READY
`ifdef BUFFER_FIFO_NX_COUNT_EN
   ,
   output logic [AW:0]      COUNT
`endif
);

   // Pointer increment constant, sized to the pointer so no width mismatch.
   localparam logic [AW:0] C_PTR_ONE = {{AW{1'b0}}, 1'b1};

   // Pointers carry one extra MSB so full and empty are distinguishable
   // when the index bits coincide.
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [WIDTH-1:0] r_mem [DEPTH];

   logic [AW-1:0]    w_wr_idx;
   logic [AW-1:0]    w_rd_idx;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;

   assign w_wr_idx = r_wr_ptr[AW-1:0];
   assign w_rd_idx = r_rd_ptr[AW-1:0];

   // Status flags come only from registered pointers, so neither ready nor
   // valid has a combinational path from the opposite handshake input.
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (w_wr_idx == w_rd_idx);

   assign I_READY = ~w_full;
   assign O_VALID = ~w_empty;

   assign w_push  = I_VALID & ~w_full;
   assign w_pop   = O_READY & ~w_empty;

   // Head entry is presented directly from storage (fall-through read).
   assign O = r_mem[w_rd_idx];

   // Write pointer: advance on every accepted word; reset wins over push.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wr_ptr <= '0;
      end else if (w_push) begin
         r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
   end

   // Read pointer: advance on every consumed word; reset wins over pop.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_rd_ptr <= '0;
      end else if (w_pop) begin
         r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
   end

   // Storage: one register per entry, cleared on reset so O reads zero
   // while the buffer is empty after reset.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
         // Capture write data into this entry when it is the write target.
         always_ff @(posedge CLK) begin
            if (RST) begin
               r_mem[gi] <= '0;
            end else if (w_push && (w_wr_idx == AW'(gi))) begin
               r_mem[gi] <= I;
            end
         end
      end
   endgenerate

`ifdef BUFFER_FIFO_NX_COUNT_EN
   // Occupancy is the modulo-2*DEPTH pointer distance; it moves on the same
   // edge as the pointers and stays put when push and pop coincide.
   assign COUNT = r_wr_ptr - r_rd_ptr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_buffer_fifo_nx.sv
`default_nettype none
// ============================================================================
// Module   : tb_buffer_fifo_nx
// Purpose  : Self-checking bench for buffer_fifo_nx. Accepted input words are
//            queued as expected output; a monitor pops and compares on every
//            output handshake. Directed checks cover reset, fill, drain,
//            streaming, random stalls and mid-operation reset.
// Options  : honours BUFFER_FIFO_NX_COUNT_EN (checks COUNT when defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_buffer_fifo_nx;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic             CLK     = 1'b0;
   logic             RST     = 1'b1;
   logic [WIDTH-1:0] I       = '0;
   logic             I_VALID = 1'b0;
   logic             I_READY;
   logic [WIDTH-1:0] O;
   logic             O_VALID;
   logic             O_READY = 1'b0;
`ifdef BUFFER_FIFO_NX_COUNT_EN
   logic [AW:0]      COUNT;
`endif

   int n_checks = 0;
   int n_errors = 0;

   logic [WIDTH-1:0] exp_q[$];

   buffer_fifo_nx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .CLK     (CLK),
      .RST     (RST),
      .I       (I),
      .I_VALID (I_VALID),
      .I_READY (I_READY),
      .O       (O),
      .O_VALID (O_VALID),
      .O_READY (O_READY)
`ifdef BUFFER_FIFO_NX_COUNT_EN
      ,
      .COUNT   (COUNT)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   // Input-side scoreboard: checks flags against model occupancy, then
   // records the word that the coming rising edge will accept.
   always @(negedge CLK) begin
      if (RST) begin
         exp_q.delete();
      end else begin
         chk("o_valid_vs_model", 32'(O_VALID), 32'(exp_q.size() != 0));
         chk("i_ready_vs_model", 32'(I_READY), 32'(exp_q.size() < DEPTH));
`ifdef BUFFER_FIFO_NX_COUNT_EN
         chk("count_vs_model", 32'(COUNT), 32'(exp_q.size()));
`endif
         if (I_VALID && I_READY) exp_q.push_back(I);
      end
   end

   // Output monitor: compares each consumed word and checks O holds steady
   // while the consumer stalls.
   logic [WIDTH-1:0] prev_o;
   logic             prev_stall = 1'b0;
   always @(negedge CLK) begin
      #1;
      if (RST) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("o_hold_valid", 32'(O_VALID), 32'd1);
            chk("o_hold_data", 32'(O), 32'(prev_o));
         end
         if (O_VALID && O_READY) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL pop_underflow: got 0x%0h expected no output at %0t", O, $time);
            end else begin
               chk("data_out", 32'(O), 32'(exp_q.pop_front()));
            end
         end
         prev_stall = O_VALID && !O_READY;
         prev_o     = O;
      end
   end

   // Hard stop if the run ever stalls.
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic drain_to_empty();
      bit done = 0;
      I_VALID = 1'b0;
      O_READY = 1'b1;
      for (int k = 0; k < 20 && !done; k++) begin
         if (!O_VALID) done = 1;
         else cyc();
      end
      chk("drain_bounded", 32'(O_VALID), 32'd0);
      O_READY = 1'b0;
   endtask

   logic [WIDTH-1:0] fill_words [4];

   initial begin
      fill_words[0] = 8'h11;
      fill_words[1] = 8'h22;
      fill_words[2] = 8'h33;
      fill_words[3] = 8'h44;

      // Reset held two cycles with a word offered: nothing is stored.
      RST = 1'b1; I_VALID = 1'b1; I = 8'hAB; O_READY = 1'b0;
      cyc(); cyc();
      chk("rst_o", 32'(O), 32'h0);
      chk("rst_o_valid", 32'(O_VALID), 32'd0);
      chk("rst_i_ready", 32'(I_READY), 32'd1);
`ifdef BUFFER_FIFO_NX_COUNT_EN
      chk("rst_count", 32'(COUNT), 32'd0);
`endif
      RST = 1'b0; I_VALID = 1'b0;
      cyc();
      chk("post_rst_empty", 32'(O_VALID), 32'd0);

      // Fill with the consumer stalled.
      for (int k = 0; k < 4; k++) begin
         I = fill_words[k]; I_VALID = 1'b1;
         cyc();
      end
      chk("full_i_ready", 32'(I_READY), 32'd0);
      chk("full_o_valid", 32'(O_VALID), 32'd1);
      chk("full_head", 32'(O), 32'h11);
      I = 8'h55;
      cyc(); cyc();
      chk("full_blocked_i_ready", 32'(I_READY), 32'd0);
      chk("full_blocked_head", 32'(O), 32'h11);
`ifdef BUFFER_FIFO_NX_COUNT_EN
      chk("full_count", 32'(COUNT), 32'd4);
`endif

      // Drain from full; I_READY returns the cycle after the first pop.
      I_VALID = 1'b0; O_READY = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("drain_valid", 32'(O_VALID), 32'd1);
         chk("drain_data", 32'(O), 32'(fill_words[k]));
         cyc();
         if (k == 0) chk("drain_i_ready_rise", 32'(I_READY), 32'd1);
      end
      chk("drain_empty", 32'(O_VALID), 32'd0);

      // Streaming 0..19 with both sides always ready: no gaps, 5 wraps.
      O_READY = 1'b1;
      for (int k = 0; k < 20; k++) begin
         I = WIDTH'(k); I_VALID = 1'b1;
         cyc();
         chk("stream_valid", 32'(O_VALID), 32'd1);
         chk("stream_data", 32'(O), 32'(k));
      end
      I_VALID = 1'b0;
      cyc();
      chk("stream_end_empty", 32'(O_VALID), 32'd0);
      O_READY = 1'b0;

      // Random stalls on both sides; producer holds data while stalled.
      for (int k = 0; k < 1000; k++) begin
         if (!(I_VALID && !I_READY)) begin
            I_VALID = ($urandom_range(0, 99) < 60);
            I       = WIDTH'($urandom);
         end
         O_READY = ($urandom_range(0, 99) < 50);
         cyc();
      end
      drain_to_empty();

      // Reset in the middle of operation while a push is offered.
      for (int k = 1; k <= 3; k++) begin
         I = WIDTH'(k); I_VALID = 1'b1;
         cyc();
      end
      I = 8'h99; I_VALID = 1'b1; RST = 1'b1;
      cyc();
      RST = 1'b0; I_VALID = 1'b0;
      chk("midrst_o_valid", 32'(O_VALID), 32'd0);
      chk("midrst_i_ready", 32'(I_READY), 32'd1);
`ifdef BUFFER_FIFO_NX_COUNT_EN
      chk("midrst_count", 32'(COUNT), 32'd0);
`endif
      I = 8'hA5; I_VALID = 1'b1;
      cyc();
      I_VALID = 1'b0;
      chk("midrst_first_valid", 32'(O_VALID), 32'd1);
      chk("midrst_first_data", 32'(O), 32'hA5);
      O_READY = 1'b1;
      cyc();
      chk("midrst_final_empty", 32'(O_VALID), 32'd0);
      O_READY = 1'b0;
      cyc(); cyc();
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/buffer_fifo_nx.md
Name: buffer_fifo_nx

Overview:
Parametrised registered successor to the two-stage inverter buffer. It is a WIDTH-bit, DEPTH-entry synchronous FIFO buffer with valid/ready handshakes on both sides. It sits between producer and consumer datapaths in generated digital blocks to absorb stalls and retime data. The target mapping is sky130 flip-flops plus inv/mux cells through the verilog-to-laygo flow.

Parameters:
WIDTH, 8, data bit width (>=1)
DEPTH, 4, number of storage entries; power of two, >=2
AW, $clog2(DEPTH), pointer width; derived, never overridden

Ports:
CLK  input  1  single clock; all state updates on rising edge
RST  input  1  synchronous, active-high reset
I  input  WIDTH  write data
I_VALID  input  1  producer offers I this cycle
I_READY  output  1  buffer can accept; equals !full
O  output  WIDTH  read data; head entry
O_VALID  output  1  O holds valid data; equals !empty
O_READY  input  1  consumer accepts O this cycle

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous and active-high, sampled only on the CLK rising edge.
- Reset values:
  - wr_ptr = 0 and rd_ptr = 0, each AW+1 bits.
  - All storage entries = 0.
  - O = 0, O_VALID = 0, I_READY = 1.
- Push: occurs when I_VALID && I_READY at the rising edge. mem[wr_ptr[AW-1:0]] <= I, then wr_ptr++.
- Pop: occurs when O_VALID && O_READY at the rising edge. rd_ptr++.
- Pointer wrap: pointers wrap naturally modulo 2*DEPTH. The extra MSB distinguishes full from empty.
  - empty = (wr_ptr == rd_ptr).
  - full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]).
- Output path:
  - O = mem[rd_ptr[AW-1:0]], combinational read of registered storage (first-word fall-through).
  - I_READY and O_VALID depend only on registered pointers, never combinationally on I_VALID or O_READY.
- Latency: a word pushed into an empty buffer appears on O with O_VALID=1 the cycle after the push edge. There is no same-cycle bypass.
- Simultaneous push and pop, not full and not empty: both pointers advance and occupancy is unchanged.
- Push while full: blocked because I_READY=0. Data on I is ignored, and I_VALID may stay high.
- Pop while empty: blocked because O_VALID=0. O_READY is ignored.
- Full with O_READY=1: the pop completes. I_READY rises the next cycle, not the same cycle.
- Handshake contract, checked by the bench, not enforced by the RTL:
  - Producer holds I stable while I_VALID && !I_READY.
  - Buffer holds O stable while O_VALID && !O_READY.
- Reset mid-operation: RST=1 overrides any push or pop in that cycle. All contents are discarded and the block returns to its reset values on that edge.
- Occupancy throughput: 1 word/cycle sustained when both sides are always ready.

Optional Feature:
Macro: BUFFER_FIFO_NX_COUNT_EN
- Defined:
  - Adds output port COUNT [AW:0] = wr_ptr - rd_ptr (occupancy 0..DEPTH), registered-pointer based.
  - COUNT reset value is 0.
  - COUNT updates on the same edge as the pointers: +1 on push only, -1 on pop only, unchanged on both or neither.
- Undefined: the COUNT port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold RST=1 for 2 cycles with I_VALID=1 -> O=0, O_VALID=0, I_READY=1, no push occurs (COUNT=0 if enabled).
- Fill, WIDTH=8, DEPTH=4, O_READY=0: push 0x11, 0x22, 0x33, 0x44 -> I_READY=0 after the 4th push edge; a 5th word 0x55 held on I is not stored (COUNT=4).
- Drain: from full, O_READY=1 -> O reads 0x11, 0x22, 0x33, 0x44 on consecutive cycles; I_READY=1 the cycle after the first pop; O_VALID=0 after the 4th pop.
- Streaming: I_VALID=1 and O_READY=1 continuously with data 0..19 -> output sequence 0..19 in order, first word one cycle after the first push, no gaps; wrap-around exercised 5 times.
- Random stall: 1000 cycles of random I_VALID/O_READY against a scoreboard model -> zero data mismatches, no push while full or pop while empty, O stable while O_VALID && !O_READY.
- Mid-operation reset: with 3 words stored, assert RST for 1 cycle while pushing 0x99 -> next cycle O_VALID=0, COUNT=0, 0x99 is not present; the next push of 0xA5 emerges as the first output.
